// File: rtl/instr_buffer_if.sv
// Fetch/decode-facing bundle for the instruction buffer.
// The master side is fetch+decode (the environment); the slave side is the buffer itself.
interface instr_buffer_if #(
  parameter int unsigned MACHINE_WIDTH = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned XLEN          = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                                flush;
  logic [MACHINE_WIDTH-1:0]            in_valid;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  in_inst;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  in_pc;
  logic                                in_ready;
  logic [MACHINE_WIDTH-1:0]            out_valid;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  out_inst;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0]  out_pc;
  logic                                decode_stall;
  logic [CNT_W-1:0]                    occupancy;

  modport master (
    output flush, in_valid, in_inst, in_pc, decode_stall,
    input  in_ready, out_valid, out_inst, out_pc, occupancy
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, decode_stall,
    output in_ready, out_valid, out_inst, out_pc, occupancy
  );
endinterface

// File: rtl/instr_buffer.sv
// Circular instruction buffer between fetch and decode: lane-compacting enqueue,
// in-order multi-lane dequeue, no bypass, flush on redirect.
module instr_buffer #(
  parameter int unsigned MACHINE_WIDTH = 4,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned XLEN          = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_buffer_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  ptr_t r_head, r_tail;
  cnt_t r_count;

  logic [XLEN-1:0] r_mem_inst [DEPTH];
  logic [XLEN-1:0] r_mem_pc   [DEPTH];

  logic                               w_in_ready;
  logic                               w_enq;
  logic                               w_deq;
  logic [MACHINE_WIDTH-1:0]           w_out_valid;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0] w_out_inst;
  logic [MACHINE_WIDTH-1:0][XLEN-1:0] w_out_pc;
  ptr_t                               w_wr_idx [MACHINE_WIDTH];
  cnt_t                               w_n_in;
  cnt_t                               w_n_out;
  cnt_t                               w_count_nxt;

  // Registered count only: a dequeue in the same cycle does not free room for fetch.
  assign w_in_ready = (r_count <= cnt_t'(DEPTH - MACHINE_WIDTH));
  assign w_enq      = w_in_ready && !bus.flush && (|bus.in_valid);
  assign w_deq      = !bus.decode_stall && !bus.flush;

  // Valid lanes pack into consecutive slots starting at tail.
  always_comb begin
    w_n_in = '0;
    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
      w_wr_idx[i] = r_tail + w_n_in[PTR_W-1:0];
      if (bus.in_valid[i]) w_n_in = w_n_in + cnt_t'(1);
    end
  end

  always_comb begin
    w_n_out = '0;
    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
      w_out_valid[i] = !bus.flush && (r_count > cnt_t'(i));
      w_out_inst[i]  = r_mem_inst[r_head + ptr_t'(i)];
      w_out_pc[i]    = r_mem_pc[r_head + ptr_t'(i)];
      if (w_out_valid[i]) w_n_out = w_n_out + cnt_t'(1);
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq) w_count_nxt = w_count_nxt + w_n_in;
    if (w_deq) w_count_nxt = w_count_nxt - w_n_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + ptr_t'(w_n_in);
      if (w_deq) r_head <= r_head + ptr_t'(w_n_out);
      r_count <= w_count_nxt;
    end
  end

  // Storage holds no state that matters until the pointers cover it, so it has no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < MACHINE_WIDTH; i++) begin
      if (w_enq && bus.in_valid[i]) begin
        r_mem_inst[w_wr_idx[i]] <= bus.in_inst[i];
        r_mem_pc[w_wr_idx[i]]   <= bus.in_pc[i];
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_inst  = w_out_inst;
  assign bus.out_pc    = w_out_pc;
  assign bus.occupancy = r_count;

endmodule
